// File: rtl/avmm_arb_pkg.sv
// Shared types and constants for the N-master Avalon-MM arbiter.
// Optional stall counters are built only when AVMM_ARB_STALL_CNT_EN is defined.
package avmm_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int   STALL_CNT_W = 16;
  localparam logic BURSTCOUNT  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/avmm_mp_arbiter_if.sv
// Bundles the N master ports and the single shared slave port of the arbiter.
// Modports: arb (the arbiter itself), master (processor side), slave (shared slave side).
interface avmm_mp_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS*ADDR_W-1:0]     m_address;
  logic [N_MASTERS-1:0]            m_read;
  logic [N_MASTERS-1:0]            m_write;
  logic [N_MASTERS*DATA_W-1:0]     m_writedata;
  logic [N_MASTERS*DATA_W/8-1:0]   m_byteenable;
  logic [N_MASTERS-1:0]            m_waitrequest;
  logic [DATA_W-1:0]               m_readdata;
  logic [N_MASTERS-1:0]            m_readdatavalid;

  logic [ADDR_W-1:0]               s_address;
  logic                            s_read;
  logic                            s_write;
  logic [DATA_W-1:0]               s_writedata;
  logic [DATA_W/8-1:0]             s_byteenable;
  logic                            s_burstcount;
  logic                            s_waitrequest;
  logic [DATA_W-1:0]               s_readdata;
  logic                            s_readdatavalid;

  modport arb (
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid,
    output s_address, s_read, s_write, s_writedata, s_byteenable, s_burstcount,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport master (
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_byteenable, s_burstcount,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/avmm_arb_rr.sv
// Combinational round-robin picker: first eligible requester after last_grant, wrapping.
// Zero latency; no backpressure of its own.
module avmm_arb_rr
  import avmm_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_vld
);

  int               idx;
  logic [IDX_W-1:0] idx_w;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    winner_vld = 1'b0;
    idx        = 0;
    idx_w      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      idx_w = IDX_W'(idx);
      if (!winner_vld && eligible[idx_w]) begin
        winner_vld       = 1'b1;
        winner_oh[idx_w] = 1'b1;
        winner_idx       = idx_w;
      end
    end
  end

endmodule

// File: rtl/avmm_mp_arbiter.sv
// Round-robin N-master Avalon-MM arbiter, one IDLE bubble per grant, in-order read return via pending-ID FIFO.
// Optional per-master stall counters under AVMM_ARB_STALL_CNT_EN.
module avmm_mp_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_PEND  = 4
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset,
  avmm_mp_arbiter_if.arb                    bus,
`ifdef AVMM_ARB_STALL_CNT_EN
  input  logic                              stall_cnt_clr,
  output logic [N_MASTERS*STALL_CNT_W-1:0]  stall_cnt,
`endif
  output logic                              rsp_orphan_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = clog2(N_MASTERS);
  localparam int PTR_W = (MAX_PEND > 1) ? clog2(MAX_PEND) : 1;
  localparam int CNT_W = clog2(MAX_PEND) + 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
  logic [BE_W-1:0]   s_byteenable_q, s_byteenable_d;

  logic [IDX_W-1:0]  fifo_q [MAX_PEND];
  logic [IDX_W-1:0]  fifo_d [MAX_PEND];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              orphan_q, orphan_d;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [N_MASTERS-1:0] m_waitrequest_c;
  logic [N_MASTERS-1:0] m_readdatavalid_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PEND - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req      = bus.m_read | bus.m_write;
    eligible = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      eligible[i] = bus.m_read[i] ? (count_q < CNT_W'(MAX_PEND)) : bus.m_write[i];
    end
  end

  avmm_arb_rr #(.N(N_MASTERS), .IDX_W(IDX_W)) u_rr (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .winner_vld (win_vld)
  );

  assign accept = (state_q == ARB_GRANT) && (s_read_q || s_write_q) && !bus.s_waitrequest;
  assign push   = accept && s_read_q;
  assign pop    = bus.s_readdatavalid && (count_q != '0);

  // Command is captured once at grant; masters hold it stable while stalled.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    s_address_d    = s_address_q;
    s_read_d       = s_read_q;
    s_write_d      = s_write_q;
    s_writedata_d  = s_writedata_q;
    s_byteenable_d = s_byteenable_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          state_d        = ARB_GRANT;
          grant_d        = win_idx;
          s_address_d    = bus.m_address[win_idx*ADDR_W +: ADDR_W];
          s_read_d       = |(win_oh & bus.m_read);
          s_write_d      = |(win_oh & bus.m_write & ~bus.m_read);
          s_writedata_d  = bus.m_writedata[win_idx*DATA_W +: DATA_W];
          s_byteenable_d = bus.m_byteenable[win_idx*BE_W +: BE_W];
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_q;
          s_read_d     = 1'b0;
          s_write_d    = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    orphan_d = orphan_q | (bus.s_readdatavalid && (count_q == '0));
    if (push) begin
      fifo_d[wr_ptr_q] = grant_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    m_waitrequest_c   = '1;
    m_readdatavalid_c = '0;
    if (state_q == ARB_GRANT) m_waitrequest_c[grant_q] = bus.s_waitrequest;
    if (pop) m_readdatavalid_c[fifo_q[rd_ptr_q]] = 1'b1;
  end

  // last_grant resets to the top index so the first pick after reset starts at master 0.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= ARB_IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(N_MASTERS - 1);
      s_address_q    <= '0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_writedata_q  <= '0;
      s_byteenable_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      orphan_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      s_address_q    <= s_address_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
      s_writedata_q  <= s_writedata_d;
      s_byteenable_q <= s_byteenable_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      orphan_q       <= orphan_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.m_waitrequest   = m_waitrequest_c;
  assign bus.m_readdatavalid = m_readdatavalid_c;
  assign bus.m_readdata      = bus.s_readdata;
  assign bus.s_address       = s_address_q;
  assign bus.s_read          = s_read_q;
  assign bus.s_write         = s_write_q;
  assign bus.s_writedata     = s_writedata_q;
  assign bus.s_byteenable    = s_byteenable_q;
  assign bus.s_burstcount    = BURSTCOUNT;
  assign rsp_orphan_err      = orphan_q;

`ifdef AVMM_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q [N_MASTERS];
  logic [STALL_CNT_W-1:0] stall_d [N_MASTERS];

  always_comb begin
    stall_d   = stall_q;
    stall_cnt = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (stall_cnt_clr) begin
        stall_d[i] = '0;
      end else if (req[i] && m_waitrequest_c[i] && (stall_q[i] != '1)) begin
        stall_d[i] = stall_q[i] + 1'b1;
      end
      stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] = stall_q[i];
    end
  end

  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (reset_reset) stall_q[i] <= '0;
      else             stall_q[i] <= stall_d[i];
    end
  end
`else
  logic unused_req;
  assign unused_req = ^req;
`endif

endmodule

// File: doc/avmm_mp_arbiter.md
Name: avmm_mp_arbiter

Overview:
- Parametrised N-master Avalon-MM arbiter. Lets N processor subsystems' out_bridge master ports share one Avalon-MM slave, such as shared on-chip memory or a mailbox.
- Sits between the proc_* instances and the shared slave in the multi-processor top level.
- Round-robin grant. Pipelined reads with in-order return routing through a pending-ID FIFO. Single-beat transfers only.

Parameters:
N_MASTERS, 4, number of master ports (2..16)
ADDR_W, 10, word address width
DATA_W, 32, data width (multiple of 8)
MAX_PEND, 4, max outstanding reads accepted by the slave (power of 2, >=1)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
m_address  in  N_MASTERS*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
m_read  in  N_MASTERS  per-master read request
m_write  in  N_MASTERS  per-master write request
m_writedata  in  N_MASTERS*DATA_W  per-master write data
m_byteenable  in  N_MASTERS*DATA_W/8  per-master byte enables
m_waitrequest  out  N_MASTERS  per-master stall
m_readdata  out  DATA_W  read data, broadcast to all masters
m_readdatavalid  out  N_MASTERS  one-hot read return strobe
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_burstcount  out  1  constant 1
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read return
rsp_orphan_err  out  1  sticky: readdatavalid arrived with no pending read

Behaviour:
- Reset:
  - State returns to IDLE; grant register, pointers, FIFO count and rsp_orphan_err clear.
  - m_waitrequest is all 1s. s_read, s_write, m_readdatavalid are 0. s_address, s_writedata, s_byteenable are 0. rsp_orphan_err is 0.
  - Reset mid-transfer abandons all in-flight reads; no responses are delivered for them.
- Request: master i requests when m_read[i] | m_write[i]. Masters must hold the command stable while m_waitrequest[i]=1. m_read and m_write together on one master is illegal; read wins.
- FSM:
  - IDLE: pick a winner among eligible requesters, round-robin starting at (last_grant+1) mod N_MASTERS. Register the grant and go to GRANT. With no eligible requester, stay in IDLE.
  - Eligibility: a write is always eligible. A read is eligible only if FIFO count < MAX_PEND.
  - GRANT: drive s_* from the granted master's command (registered mux). m_waitrequest[g] = s_waitrequest; all other masters see 1.
  - Accept = (s_read|s_write) & !s_waitrequest. On accept: go to IDLE, update last_grant=g, and for a read push g into the FIFO.
- Latency:
  - Command asserted at cycle t with the arbiter idle: s_* valid at t+1, earliest accept at t+1.
  - Back-to-back grants have one IDLE bubble, so the maximum issue rate is 1 per 2 cycles.
- Read return:
  - On s_readdatavalid, pop the FIFO head h. m_readdatavalid[h]=1 and m_readdata=s_readdata in the same cycle (combinational path).
  - Returns follow strict slave order.
- Simultaneous push and pop in the same cycle: count unchanged, both take effect.
- Full FIFO: reads stay ineligible until a pop; writes still proceed.
- Empty FIFO with s_readdatavalid=1: no m_readdatavalid, rsp_orphan_err set until reset.
- Pointers wrap modulo MAX_PEND. Count width is clog2(MAX_PEND)+1.

Optional Feature:
AVMM_ARB_STALL_CNT_EN
- With the macro: adds input stall_cnt_clr (1 bit) and output stall_cnt (N_MASTERS*16).
  - Counter i increments on each cycle where master i requests and m_waitrequest[i]=1, saturating at 16'hFFFF.
  - stall_cnt_clr=1 zeroes all counters, with priority over increment.
  - Reset zeroes all counters.
- Without the macro: neither port exists and no counter logic is built.

Decomposition:
- Package avmm_arb_pkg:
  - State enum (ARB_IDLE, ARB_GRANT).
  - clog2 helper function.
  - Stall counter width constant STALL_CNT_W=16.
  - Burstcount constant 1.
- Sub-module avmm_arb_rr: combinational round-robin picker. Inputs: eligible vector, last_grant. Outputs: one-hot winner plus index.
- The pending-ID FIFO stays inline.

Test Plan:
- Single master 0 writes 0xCAFEBABE to addr 0x005, s_waitrequest=0 -> s_write=1 one cycle after request, m_waitrequest[0]=0 that cycle, s_writedata=0xCAFEBABE.
- Masters 0..3 all write continuously, last_grant reset -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Slave holds s_waitrequest=1 for 5 cycles on master 2's read -> s_read stays asserted and stable, m_waitrequest[2]=1 for 5 cycles, then accept; other masters are not granted in between.
- MAX_PEND=4, 5 reads from masters 1,3,1,0,2, slave withholds readdatavalid -> 4 accepted, 5th not granted. Return data 0x11,0x22,0x33,0x44 -> m_readdatavalid one-hot to 1,3,1,0 in order. Master 2 is then granted.
- s_readdatavalid=1 with FIFO empty -> all m_readdatavalid=0, rsp_orphan_err=1 and held until reset_reset.
- reset_reset pulsed with 2 reads pending -> later s_readdatavalid sets rsp_orphan_err and no m_readdatavalid fires. With AVMM_ARB_STALL_CNT_EN, stall_cnt reads 0 after reset.
